// File: rtl/byte_bus_pkg.sv
// Shared constants for the byte-wide memory bus.
//
// Holds the bus byte width, the word width and the responder FSM state
// encoding. The x3q16 memory controller reuses the width constants so both
// ends of the bus agree on byte and word sizes.

package byte_bus_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR_ACTIVE = 3'd1;
    localparam state_t ST_RD_ADDR   = 3'd2;
    localparam state_t ST_RD_FETCH  = 3'd3;
    localparam state_t ST_RD_LOWER  = 3'd4;
    localparam state_t ST_RD_UPPER  = 3'd5;

endpackage

// File: rtl/byte_bus_sync.sv
// Parameterized-width two-flop synchronizer.
//
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high reset; both stages clear to 0
//   d      - asynchronous input vector
//   q      - synchronized output vector, two clk cycles behind d

module byte_bus_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/byte_bus_memory_responder.sv
// Target-side responder of the byte-wide memory bus.
//
// Decodes the controller strobes, assembles a 16-bit address and 16-bit write
// data from byte transfers, owns a 2**ADDR_W x 16 memory array and returns
// read data one byte at a time with the lower/upper byte-ready handshake.
//
// Ports:
//   clk              - system clock
//   reset            - asynchronous, active-high reset
//   write_enable     - controller write transaction active
//   read_enable      - controller read transaction active
//   register_enable  - 1 = address phase, 0 = data phase
//   lower_bit        - bus carries the low byte
//   upper_bit        - bus carries the high byte
//   bus_in           - byte driven by the controller
//   bus_out          - read-data byte to the controller
//   lower_byte_ready - bus_out holds the low read byte
//   upper_byte_ready - bus_out holds the high read byte
//   protocol_error   - sticky error flag, cleared only by reset
//
// Configuration macro BYTE_BUS_SYNC_INPUTS_EN: when defined, every control
// input and bus_in pass through a two-flop synchronizer, adding two cycles to
// every input-referenced latency. Leave it undefined for a same-clock on-chip
// controller.

module byte_bus_memory_responder
    import byte_bus_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RESP_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic              register_enable,
    input  logic              lower_bit,
    input  logic              upper_bit,
    input  logic [BYTE_W-1:0] bus_in,
    output logic [BYTE_W-1:0] bus_out,
    output logic              lower_byte_ready,
    output logic              upper_byte_ready,
    output logic              protocol_error
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int HOLD_W = $clog2(RESP_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESP_HOLD - 1);

    logic              we;
    logic              re;
    logic              reg_sel;
    logic              lo;
    logic              up;
    logic [BYTE_W-1:0] bus;

`ifdef BYTE_BUS_SYNC_INPUTS_EN
    byte_bus_sync #(
        .W(BYTE_W + 5)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    ({write_enable, read_enable, register_enable, lower_bit, upper_bit, bus_in}),
        .q    ({we, re, reg_sel, lo, up, bus})
    );
`else
    assign we      = write_enable;
    assign re      = read_enable;
    assign reg_sel = register_enable;
    assign lo      = lower_bit;
    assign up      = upper_bit;
    assign bus     = bus_in;
`endif

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   addr_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [WORD_W-1:0]   rdata_reg;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   mem_index;
    logic                both_bytes;
    logic                err_set;
    logic                mem_write;
    logic [BYTE_W-1:0]   next_bus_out;
    logic                next_lower;
    logic                next_upper;

    // Address bits above ADDR_W are captured but deliberately ignored, so
    // addresses alias modulo the depth of the array.
    assign mem_index = addr_reg[ADDR_W-1:0];

    generate
        if (ADDR_W < WORD_W) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^addr_reg[WORD_W-1:ADDR_W];
        end
    endgenerate

    assign both_bytes = lo & up;

    // The write commits on the first cycle write_enable is seen low, using the
    // fields captured up to the previous cycle; a rising read_enable wins.
    assign mem_write = (state == ST_WR_ACTIVE) && !re && !we;

    assign err_set = both_bytes
                   || ((state == ST_IDLE) && we && re)
                   || ((state == ST_WR_ACTIVE) && re);

    // Field capture runs in every state; a cycle with both byte strobes high
    // is ambiguous and captures nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (!both_bytes) begin
            if (reg_sel && lo) addr_reg[BYTE_W-1:0]       <= bus;
            if (reg_sel && up) addr_reg[WORD_W-1:BYTE_W]  <= bus;
            if (!reg_sel && lo) wdata_reg[BYTE_W-1:0]     <= bus;
            if (!reg_sel && up) wdata_reg[WORD_W-1:BYTE_W] <= bus;
        end
    end

    // Memory array and its synchronous read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[mem_index] <= wdata_reg;
        end
        if (state == ST_RD_FETCH) begin
            rdata_reg <= mem[mem_index];
        end
    end

    // State register plus the registered outputs, so every output change
    // appears one cycle after the state that caused it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            hold_cnt         <= '0;
            bus_out          <= '0;
            lower_byte_ready <= 1'b0;
            upper_byte_ready <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            state            <= next_state;
            hold_cnt         <= (state == ST_RD_LOWER) ? hold_cnt + HOLD_W'(1) : '0;
            bus_out          <= next_bus_out;
            lower_byte_ready <= next_lower;
            upper_byte_ready <= next_upper;
            if (err_set) protocol_error <= 1'b1;
        end
    end

    // Next-state decode; dropping read_enable aborts any read phase.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (we && !re)      next_state = ST_WR_ACTIVE;
                else if (re && !we) next_state = ST_RD_ADDR;
            end
            ST_WR_ACTIVE: begin
                if (re || !we) next_state = ST_IDLE;
            end
            ST_RD_ADDR: begin
                if (!re)                           next_state = ST_IDLE;
                else if (reg_sel && up && !lo)     next_state = ST_RD_FETCH;
            end
            ST_RD_FETCH: begin
                next_state = re ? ST_RD_LOWER : ST_IDLE;
            end
            ST_RD_LOWER: begin
                if (!re)                        next_state = ST_IDLE;
                else if (hold_cnt == HOLD_LAST) next_state = ST_RD_UPPER;
            end
            ST_RD_UPPER: begin
                if (!re) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode from the current state, registered above.
    always_comb begin
        next_bus_out = '0;
        next_lower   = 1'b0;
        next_upper   = 1'b0;
        case (state)
            ST_RD_LOWER: begin
                next_bus_out = rdata_reg[BYTE_W-1:0];
                next_lower   = 1'b1;
            end
            ST_RD_UPPER: begin
                next_bus_out = rdata_reg[WORD_W-1:BYTE_W];
                next_upper   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_byte_bus_memory_responder.sv
// Directed testbench for byte_bus_memory_responder: writes, reads, aliasing,
// read abort, protocol errors and reset behaviour, with hand-computed values.

module tb_byte_bus_memory_responder;

    localparam int RESP_HOLD = 16;
`ifdef BYTE_BUS_SYNC_INPUTS_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LOWER_LAT = 3 + SYNC_LAT;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic       read_enable;
    logic       register_enable;
    logic       lower_bit;
    logic       upper_bit;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       lower_byte_ready;
    logic       upper_byte_ready;
    logic       protocol_error;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    byte_bus_memory_responder #(
        .ADDR_W   (8),
        .RESP_HOLD(RESP_HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .register_enable (register_enable),
        .lower_bit       (lower_bit),
        .upper_bit       (upper_bit),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .lower_byte_ready(lower_byte_ready),
        .upper_byte_ready(upper_byte_ready),
        .protocol_error  (protocol_error)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Drives one bus cycle on the falling edge, sampled by the next rising edge.
    task automatic applyStimulus(input logic we, input logic re, input logic rg,
                                 input logic lo, input logic up, input logic [7:0] b);
        @(negedge clk);
        write_enable    = we;
        read_enable     = re;
        register_enable = rg;
        lower_bit       = lo;
        upper_bit       = up;
        bus_in          = b;
    endtask

    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 0, 1, 1, 0, addr[7:0]);
        applyStimulus(1, 0, 1, 0, 1, addr[15:8]);
        applyStimulus(1, 0, 0, 1, 0, data[7:0]);
        applyStimulus(1, 0, 0, 0, 1, data[15:8]);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
    endtask

    // Sends the read address and waits (bounded) for lower_byte_ready.
    task automatic startRead(input string tag, input logic [15:0] addr, output int lat);
        logic seen;
        applyStimulus(0, 1, 0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 1, 0, addr[7:0]);
        applyStimulus(0, 1, 1, 0, 1, addr[15:8]);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            register_enable = 1'b0;
            lower_bit       = 1'b0;
            upper_bit       = 1'b0;
            bus_in          = 8'h00;
            if (lower_byte_ready) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        checkOutput({tag, " lower_ready_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic readWord(input string tag, input logic [15:0] addr,
                            input logic [15:0] expected);
        int lat;
        int held;
        startRead(tag, addr, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(LOWER_LAT));
        checkOutput({tag, " low_byte"}, 32'(bus_out), 32'(expected[7:0]));
        held = lower_byte_ready ? 1 : 0;
        for (int i = 0; i < RESP_HOLD + 10; i++) begin
            @(negedge clk);
            if (lower_byte_ready) held++;
            else break;
        end
        checkOutput({tag, " lower_hold"}, 32'(held), 32'(RESP_HOLD));
        checkOutput({tag, " upper_ready"}, 32'(upper_byte_ready), 32'd1);
        checkOutput({tag, " high_byte"}, 32'(bus_out), 32'(expected[15:8]));
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        repeat (2 + SYNC_LAT) @(negedge clk);
        checkOutput({tag, " idle_outputs"},
                    {22'd0, upper_byte_ready, lower_byte_ready, bus_out}, 32'd0);
    endtask

    task automatic readAbort(input string tag, input logic [15:0] addr);
        int lat;
        startRead(tag, addr, lat);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        repeat (2 + SYNC_LAT) @(negedge clk);
        checkOutput({tag, " cleared_outputs"},
                    {22'd0, upper_byte_ready, lower_byte_ready, bus_out}, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " bus_out"}, 32'(bus_out), 32'd0);
        checkOutput({tag, " lower_ready"}, 32'(lower_byte_ready), 32'd0);
        checkOutput({tag, " upper_ready"}, 32'(upper_byte_ready), 32'd0);
        checkOutput({tag, " protocol_error"}, 32'(protocol_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        write_enable    = 1'b0;
        read_enable     = 1'b0;
        register_enable = 1'b0;
        lower_bit       = 1'b0;
        upper_bit       = 1'b0;
        bus_in          = 8'h00;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        writeWord(16'h00A5, 16'hBEEF);
        readWord("basic", 16'h00A5, 16'hBEEF);

        writeWord(16'h12A5, 16'h1234);
        readWord("alias", 16'h00A5, 16'h1234);

        writeWord(16'h0001, 16'h1111);
        writeWord(16'h0002, 16'h2222);
        readWord("b2b_1", 16'h0001, 16'h1111);
        readWord("b2b_2", 16'h0002, 16'h2222);
        checkOutput("no_error_yet", 32'(protocol_error), 32'd0);

        readAbort("abort", 16'h0001);
        readWord("after_abort", 16'h0001, 16'h1111);

        applyStimulus(1, 1, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        repeat (SYNC_LAT) @(negedge clk);
        checkOutput("err_set", 32'(protocol_error), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("err_sticky", 32'(protocol_error), 32'd1);
        readWord("err_read", 16'h0002, 16'h2222);
        checkOutput("err_still_set", 32'(protocol_error), 32'd1);

        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetOutputs("err_reset");
        @(negedge clk);
        reset = 1'b0;
        readWord("post_reset", 16'h0002, 16'h2222);

        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 0, 1, 1, 0, 8'h02);
        applyStimulus(1, 0, 1, 0, 1, 8'h00);
        applyStimulus(1, 0, 0, 1, 0, 8'h99);
        applyStimulus(1, 0, 0, 0, 1, 8'h99);
        @(negedge clk);
        reset           = 1'b1;
        write_enable    = 1'b0;
        register_enable = 1'b0;
        lower_bit       = 1'b0;
        upper_bit       = 1'b0;
        bus_in          = 8'h00;
        #1;
        checkResetOutputs("midwrite_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        readWord("midwrite", 16'h0002, 16'h2222);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
